// File: rtl/hazard_pkg.sv
// Shared widths, defaults and the mult/div timer state type for the hazard controller.
package hazard_pkg;

    localparam int TW = 2;
    localparam logic [TW-1:0] TUSE_NEVER = 2'd3;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef enum logic {
        IDLE,
        BUSY
    } md_state_e;

    // Counter width able to hold the larger of the two latencies.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy timer: loads a latency when an operation leaves E and holds busy until it expires.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int CW = cnt_width(MULT_LAT, DIV_LAT);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults first so no path leaves state_d/cnt_d unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q <= CNT_ONE) begin
                    // A new operation on the expiring edge chains straight on without a gap.
                    if (start) begin
                        cnt_d = is_div ? DIV_LOAD : MULT_LOAD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew register hazards plus mult/div busy stalls, with a stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    a1_d,
    input  logic [4:0]    a2_d,
    input  logic [TW-1:0] tuse_rs_d,
    input  logic [TW-1:0] tuse_rt_d,
    input  logic [4:0]    a3_e,
    input  logic [4:0]    a3_m,
    input  logic [TW-1:0] tnew_e,
    input  logic [TW-1:0] tnew_m,
    input  logic          md_op_d,
    input  logic          md_start_e,
    input  logic          md_div_e,
    output logic          en_pc,
    output logic          en_d,
    output logic          clr_e,
    output logic          md_busy,
    output logic [31:0]   stall_cnt
);

    logic        haz_rs;
    logic        haz_rt;
    logic        haz_md;
    logic        stall;
    logic [31:0] stall_cnt_q;

    md_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start_e),
        .is_div (md_div_e),
        .busy   (md_busy)
    );

    // $zero is never a real producer, so it can never hold up a consumer.
    assign haz_rs = (a1_d != 5'd0) &&
                    (((a1_d == a3_e) && (tuse_rs_d < tnew_e)) ||
                     ((a1_d == a3_m) && (tuse_rs_d < tnew_m)));
    assign haz_rt = (a2_d != 5'd0) &&
                    (((a2_d == a3_e) && (tuse_rt_d < tnew_e)) ||
                     ((a2_d == a3_m) && (tuse_rt_d < tnew_m)));
    assign haz_md = md_op_d && (md_busy || md_start_e);

    assign stall  = haz_rs || haz_rt || haz_md;
    assign en_pc  = ~stall;
    assign en_d   = ~stall;
    assign clr_e  = stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    a1_d, a2_d, a3_e, a3_m;
    logic [TW-1:0] tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
    logic          md_op_d, md_start_e, md_div_e;
    logic          en_pc, en_d, clr_e, md_busy;
    logic [31:0]   stall_cnt;

    typedef struct {
        string       name;
        logic        stall;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a1_d       (a1_d),
        .a2_d       (a2_d),
        .tuse_rs_d  (tuse_rs_d),
        .tuse_rt_d  (tuse_rt_d),
        .a3_e       (a3_e),
        .a3_m       (a3_m),
        .tnew_e     (tnew_e),
        .tnew_m     (tnew_m),
        .md_op_d    (md_op_d),
        .md_start_e (md_start_e),
        .md_div_e   (md_div_e),
        .en_pc      (en_pc),
        .en_d       (en_d),
        .clr_e      (clr_e),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a1_d = '0; a2_d = '0; a3_e = '0; a3_m = '0;
        tuse_rs_d = TUSE_NEVER; tuse_rt_d = TUSE_NEVER;
        tnew_e = '0; tnew_m = '0;
        md_op_d = 1'b0; md_start_e = 1'b0; md_div_e = 1'b0;
    endtask

    task automatic push_exp(input string nm, input logic st, input logic bz, input logic [31:0] cnt);
        exp_t e;
        e.name  = nm;
        e.stall = st;
        e.busy  = bz;
        e.cnt   = cnt;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        idle();
        a1_d = 5'd3; a3_e = 5'd3; tuse_rs_d = 2'd0; tnew_e = 2'd2;
        push_exp("reset_comb", 1'b1, 1'b0, 32'd0);
        tick();
        rst_n = 1'b1;
        idle();
        push_exp("reset_release", 1'b0, 1'b0, 32'd0);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle against queued expectations.
    exp_t e_mon;
    logic en_exp;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e_mon  = sb.pop_front();
            en_exp = ~e_mon.stall;
            check({e_mon.name, ":en_pc"},     {31'd0, en_pc},   {31'd0, en_exp});
            check({e_mon.name, ":en_d"},      {31'd0, en_d},    {31'd0, en_exp});
            check({e_mon.name, ":clr_e"},     {31'd0, clr_e},   {31'd0, e_mon.stall});
            check({e_mon.name, ":md_busy"},   {31'd0, md_busy}, {31'd0, e_mon.busy});
            check({e_mon.name, ":stall_cnt"}, stall_cnt,        e_mon.cnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        #1;
        push_exp("reset", 1'b0, 1'b0, 32'd0);
        tick(); rst_n = 1'b1; push_exp("post_reset", 1'b0, 1'b0, 32'd0);

        // Register hazards
        tick(); idle(); a1_d = 5'd5; tuse_rs_d = 2'd0; a3_e = 5'd5; tnew_e = 2'd1;
        push_exp("rs_e_hazard", 1'b1, 1'b0, 32'd0);
        tick(); idle(); push_exp("rs_e_counted", 1'b0, 1'b0, 32'd1);
        tick(); idle(); a1_d = 5'd0; tuse_rs_d = 2'd0; a3_e = 5'd0; tnew_e = 2'd2;
        a2_d = 5'd0; tuse_rt_d = 2'd0; a3_m = 5'd0; tnew_m = 2'd3;
        push_exp("zero_addr", 1'b0, 1'b0, 32'd1);
        tick(); idle(); a2_d = 5'd7; tuse_rt_d = 2'd1; a3_m = 5'd7; tnew_m = 2'd2;
        push_exp("rt_m_hazard", 1'b1, 1'b0, 32'd1);
        tick(); idle(); a2_d = 5'd7; tuse_rt_d = 2'd2; a3_m = 5'd7; tnew_m = 2'd2;
        push_exp("rt_m_equal", 1'b0, 1'b0, 32'd2);
        tick(); idle(); a2_d = 5'd9; tuse_rt_d = TUSE_NEVER; a3_e = 5'd9; tnew_e = 2'd3;
        push_exp("rt_never", 1'b0, 1'b0, 32'd2);
        tick(); idle(); a1_d = 5'd5; tuse_rs_d = 2'd0; a3_e = 5'd6; tnew_e = 2'd3;
        a3_m = 5'd5; tnew_m = 2'd0;
        push_exp("rs_other_addr", 1'b0, 1'b0, 32'd2);
        tick(); idle(); a1_d = 5'd12; tuse_rs_d = 2'd1; a3_m = 5'd12; tnew_m = 2'd2;
        push_exp("rs_m_hazard", 1'b1, 1'b0, 32'd2);
        tick(); idle(); a2_d = 5'd4; tuse_rt_d = 2'd0; a3_e = 5'd4; tnew_e = 2'd2;
        push_exp("rt_e_hazard", 1'b1, 1'b0, 32'd3);
        tick(); idle(); md_op_d = 1'b1;
        push_exp("md_op_idle", 1'b0, 1'b0, 32'd4);

        // Mult: start cycle plus five busy cycles stall; a concurrent register hazard counts once
        do_reset();
        tick(); idle(); md_start_e = 1'b1; md_op_d = 1'b1;
        push_exp("mult_start", 1'b1, 1'b0, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            tick(); idle(); md_op_d = 1'b1;
            if (i == 3) begin
                a1_d = 5'd8; tuse_rs_d = 2'd0; a3_e = 5'd8; tnew_e = 2'd1;
            end
            push_exp($sformatf("mult_busy%0d", i), 1'b1, 1'b1, i);
        end
        tick(); idle(); md_op_d = 1'b1;
        push_exp("mult_done", 1'b0, 1'b0, 32'd6);

        // Back-to-back mult: start in BUSY ignored, start on the last edge reloads
        do_reset();
        tick(); idle(); md_start_e = 1'b1;
        push_exp("b2b_start", 1'b0, 1'b0, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            tick(); idle(); md_start_e = (i == 1 || i == 5);
            push_exp($sformatf("b2b_busy%0d", i), 1'b0, 1'b1, 32'd0);
        end
        tick(); idle(); md_op_d = 1'b1;
        push_exp("b2b_done", 1'b0, 1'b0, 32'd0);

        // Div interrupted by reset at busy cycle 4
        do_reset();
        tick(); idle(); md_start_e = 1'b1; md_div_e = 1'b1;
        push_exp("div_start", 1'b0, 1'b0, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick(); idle(); md_op_d = 1'b1;
            push_exp($sformatf("div_busy%0d", i), 1'b1, 1'b1, i - 1);
        end
        tick(); rst_n = 1'b0; idle(); md_op_d = 1'b1;
        push_exp("div_rst", 1'b0, 1'b0, 32'd0);
        tick(); rst_n = 1'b1; idle(); md_op_d = 1'b1;
        push_exp("div_rst_release", 1'b0, 1'b0, 32'd0);
        tick(); idle(); md_op_d = 1'b1;
        push_exp("div_rst_idle", 1'b0, 1'b0, 32'd0);

        // Full div: exactly ten busy cycles
        tick(); idle(); md_start_e = 1'b1; md_div_e = 1'b1;
        push_exp("div2_start", 1'b0, 1'b0, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            tick(); idle();
            push_exp($sformatf("div2_busy%0d", i), 1'b0, 1'b1, 32'd0);
        end
        tick(); idle();
        push_exp("div2_done", 1'b0, 1'b0, 32'd0);

        // Stall counter wrap
        tick(); idle();
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        push_exp("wrap_load", 1'b0, 1'b0, 32'hFFFF_FFFF);
        tick(); idle(); a1_d = 5'd5; tuse_rs_d = 2'd0; a3_e = 5'd5; tnew_e = 2'd1;
        push_exp("wrap_stall", 1'b1, 1'b0, 32'hFFFF_FFFF);
        tick(); idle();
        push_exp("wrap_zero", 1'b0, 1'b0, 32'h0000_0000);

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
